onchip_ram_avmm_pipelined: RTL and testbench
============================================

# onchip_ram_avmm_pipelined

Parametrised single-port on-chip RAM Avalon-MM slave for the Qsys system, successor to the fixed 32-bit × 32500-word on-chip memory. It adds configurable width/depth, selectable read latency (1 or 2) with an explicit `readdatavalid`, back-pressure via `waitrequest`, an optional hardware zero-clear sequence after reset, and out-of-range address protection. It sits on the Nios II data/instruction interconnect as a plain memory slave.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8.
- `ADDR_WIDTH`, 15: word-address width.
- `DEPTH`, 32500: implemented words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 = unregistered RAM output, 2 = extra output register.
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset before accepting traffic.

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `clken`  in  1  global clock enable; low freezes the whole block.
- `reset_req`  in  1  high blocks RAM clocking (same effect as `clken` low).
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `address`  in  ADDR_WIDTH  word address.
- `byteenable`  in  DATA_WIDTH/8  per-byte write enable.
- `writedata`  in  DATA_WIDTH  write data.
- `readdata`  out  DATA_WIDTH  read data, valid when `readdatavalid`.
- `readdatavalid`  out  1  one-cycle pulse per accepted read.
- `waitrequest`  out  1  high: request not accepted this cycle.
- `range_err`  out  1  sticky flag: an out-of-range access occurred.

## Operation
- Enable: `en = clken & ~reset_req`. When `en`=0: no state, pipeline or RAM change; `waitrequest`=1.
- FSM states: CLEAR, READY. Reset → CLEAR if CLEAR_ON_RESET=1, else READY.
- CLEAR: counter walks 0..DEPTH-1, writes all-zero word with all bytes enabled, one word per enabled cycle; `waitrequest`=1. After writing DEPTH-1 → READY.
- READY: `waitrequest`=~`en`. Request accepted when `chipselect & ~waitrequest & (read|write)`.
- Write: bytes with `byteenable` bit set updated; others retained. `byteenable`=0 is a legal no-op.
- Read: `readdata` returns word contents as of the acceptance cycle.
- `read` and `write` both high: write performed, read dropped (no `readdatavalid`), `range_err` unaffected.
- Address ≥ DEPTH: write suppressed; read completes with `readdata`=0 and normal `readdatavalid`; `range_err` set, cleared only by `reset`.
- Reads are fully pipelined: one accept per cycle, in order, no outstanding limit.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `range_err`=0, clear counter=0.
- Read accepted in cycle N → `readdatavalid`=1 with data in cycle N+READ_LATENCY (enabled cycles; stalls via `en`=0 stretch latency, never drop data).
- Write accepted in cycle N → visible to a read accepted in cycle N+1.
- `readdatavalid` pulses exactly one enabled cycle per read; `readdata` holds its last value otherwise.
- Clear sequence duration: DEPTH enabled cycles; first accept possible in the cycle after the last clear write.
- Reset mid-clear or mid-read: pipeline flushed, no `readdatavalid` for in-flight reads, clear restarts from address 0.

## Structure
- Shared package `onchip_ram_pkg`: FSM state enum (`ST_CLEAR`, `ST_READY`), legal READ_LATENCY constants, byte-lane count function.
- Sub-module `onchip_ram_core`: inferred byte-enabled single-port RAM (DATA_WIDTH × DEPTH), synchronous read, no reset on the array.
- Top level holds FSM, clear counter, valid/data pipeline, range check, `range_err`.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16 → `waitrequest` high exactly 16 enabled cycles; reads of all 16 words return 0x00000000.
- Write 0xDEADBEEF to addr 5, then write 0x000000AA with `byteenable`=4'b0001 → read addr 5 returns 0xDEADBEAA.
- READ_LATENCY=2, back-to-back reads of addr 0..3 in consecutive cycles → four consecutive `readdatavalid` pulses, starting 2 cycles after the first accept, data in order.
- `clken` low for 3 cycles while a read is in flight → `readdatavalid` delayed by 3 cycles, data correct, `waitrequest` high during the stall.
- Read addr DEPTH (out of range) → `readdata`=0 with `readdatavalid`, `range_err`=1 and stays set; write to addr DEPTH leaves all memory unchanged.
- Assert `reset` mid-clear at counter=7 → clear restarts at 0; in-flight read at reset produces no `readdatavalid`.

Source files
------------

// File: rtl/onchip_ram_avmm_pipelined_pkg.sv
// rtl/onchip_ram_avmm_pipelined_pkg.sv - shared types and helpers for the on-chip RAM slave
package onchip_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RL_UNREG = 1;
  localparam int RL_REG   = 2;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_avmm_pipelined_if.sv
// rtl/onchip_ram_avmm_pipelined_if.sv - Avalon-MM memory slave bus bundle
interface onchip_ram_avmm_pipelined_if
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic                              chipselect;
  logic                              read;
  logic                              write;
  logic [ADDR_WIDTH-1:0]             address;
  logic [byte_lanes(DATA_WIDTH)-1:0] byteenable;
  logic [DATA_WIDTH-1:0]             writedata;
  logic [DATA_WIDTH-1:0]             readdata;
  logic                              readdatavalid;
  logic                              waitrequest;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_avmm_pipelined_core.sv
// rtl/onchip_ram_avmm_pipelined_core.sv - byte-enabled single-port RAM, synchronous read
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32500,
  parameter int AW         = 15
) (
  input  logic                              clk,
  input  logic                              ce,
  input  logic                              we,
  input  logic                              re,
  input  logic [AW-1:0]                     addr,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH-1:0]             q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // q only moves on an actual read so the top can hold readdata between reads
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int b = 0; b < byte_lanes(DATA_WIDTH); b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      if (re) q <= mem[addr];
    end
  end
endmodule

// File: rtl/onchip_ram_avmm_pipelined.sv
// rtl/onchip_ram_avmm_pipelined.sv - pipelined on-chip RAM Avalon-MM slave with clear-on-reset
module onchip_ram_avmm_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int DEPTH          = 32500,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clken,
  input  logic                        reset_req,
  onchip_ram_avmm_pipelined_if.slave  avs,
  output logic                        range_err
);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DEPTH - 1);

  state_t                            state_q, state_n;
  logic [ADDR_WIDTH-1:0]             clr_cnt_q, clr_cnt_n;
  logic                              en, in_range, accept, wr_acc, rd_acc, oor_acc;
  logic                              ram_we, ram_re;
  logic [RAM_AW-1:0]                 ram_addr;
  logic [byte_lanes(DATA_WIDTH)-1:0] ram_be;
  logic [DATA_WIDTH-1:0]             ram_wdata, ram_q, rd1, rd2_q;
  logic                              zero_q, v1_q, v2_q;

  assign en              = clken & ~reset_req;
  assign in_range        = {1'b0, avs.address} < DEPTH_W;
  assign avs.waitrequest = reset | ~en | (state_q != ST_READY);
  assign accept          = avs.chipselect & ~avs.waitrequest & (avs.read | avs.write);
  assign wr_acc          = accept & avs.write & in_range;
  assign rd_acc          = accept & avs.read & ~avs.write;
  assign oor_acc         = accept & ~in_range & ~(avs.read & avs.write);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      clr_cnt_q <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    clr_cnt_n = clr_cnt_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = RAM_AW'(avs.address);
    ram_be    = avs.byteenable;
    ram_wdata = avs.writedata;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = RAM_AW'(clr_cnt_q);
        ram_be    = '1;
        ram_wdata = '0;
        if (en) begin
          if (clr_cnt_q == LAST_W) begin
            state_n   = ST_READY;
            clr_cnt_n = '0;
          end else begin
            clr_cnt_n = clr_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        ram_we = wr_acc;
        ram_re = rd_acc & in_range;
      end
    endcase
  end

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (RAM_AW)
  ) u_core (
    .clk   (clk),
    .ce    (en),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // zero_q masks the unreset RAM output after reset and for out-of-range reads
  assign rd1 = zero_q ? '0 : ram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      zero_q    <= 1'b1;
      rd2_q     <= '0;
      range_err <= 1'b0;
    end else begin
      if (oor_acc) range_err <= 1'b1;
      if (en) begin
        v1_q <= rd_acc;
        v2_q <= v1_q;
        if (rd_acc) zero_q <= ~in_range;
        if (v1_q)   rd2_q  <= rd1;
      end
    end
  end

  assign avs.readdata      = (READ_LATENCY == RL_UNREG) ? rd1 : rd2_q;
  assign avs.readdatavalid = en & ((READ_LATENCY == RL_UNREG) ? v1_q : v2_q);
endmodule

// File: tb/tb_onchip_ram_avmm_pipelined.sv
// tb/tb_onchip_ram_avmm_pipelined.sv - directed bench for latency-1 and latency-2 RAM slaves
module tb_onchip_ram_avmm_pipelined;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic reset, clken, reset_req;
  logic range_err1, range_err2;
  int   checks = 0;
  int   errors = 0;
  int   n_en, n_all;
  logic [AW-1:0] ba [16];
  logic [31:0]   bx [16];

  onchip_ram_avmm_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  onchip_ram_avmm_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  onchip_ram_avmm_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .avs(bus1), .range_err(range_err1)
  );

  onchip_ram_avmm_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .avs(bus2), .range_err(range_err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // one bus cycle: inputs change on the falling edge, outputs sampled 1ns later
  task automatic step(input logic ce, input logic rr, input logic cs, input logic rd,
                      input logic wr, input logic [AW-1:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    @(negedge clk);
    clken = ce;
    reset_req = rr;
    bus1.chipselect = cs; bus1.read = rd; bus1.write = wr;
    bus1.address = a; bus1.byteenable = be; bus1.writedata = wd;
    bus2.chipselect = cs; bus2.read = rd; bus2.write = wr;
    bus2.address = a; bus2.byteenable = be; bus2.writedata = wd;
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, be, wd);
  endtask

  // back-to-back reads of ba[0..n-1]; dut1 returns one cycle later, dut2 two
  task automatic burst(input int n, input string tag);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ba[i], 4'h0, 32'h0);
      else idle();
      chk($sformatf("%s_rdv1_%0d", tag, i), {31'b0, bus1.readdatavalid}, {31'b0, (i >= 1 && i <= n)});
      if (i >= 1 && i <= n) chk($sformatf("%s_data1_%0d", tag, i), bus1.readdata, bx[i-1]);
      chk($sformatf("%s_rdv2_%0d", tag, i), {31'b0, bus2.readdatavalid}, {31'b0, (i >= 2)});
      if (i >= 2) chk($sformatf("%s_data2_%0d", tag, i), bus2.readdata, bx[i-2]);
    end
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    idle();
    chk("rst_readdata1", bus1.readdata, 32'h0);
    chk("rst_rdv1", {31'b0, bus1.readdatavalid}, 32'h0);
    chk("rst_waitreq1", {31'b0, bus1.waitrequest}, 32'h1);
    chk("rst_range_err1", {31'b0, range_err1}, 32'h0);
    chk("rst_readdata2", bus2.readdata, 32'h0);
    chk("rst_rdv2", {31'b0, bus2.readdatavalid}, 32'h0);

    // abort the clear at counter 7, then the full clear must take 16 enabled cycles again
    @(negedge clk); reset = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1; #1;
    chk("midclear_waitreq", {31'b0, bus1.waitrequest}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_en = 0; n_all = 0;
    for (int i = 0; i < 64; i++) begin
      clken = (i != 4);
      #1;
      if (!bus1.waitrequest) break;
      n_all++;
      if (clken) n_en++;
      @(negedge clk);
    end
    chk("clear_enabled_cycles", n_en, 16);
    chk("clear_total_cycles", n_all, 17);
    chk("clear_done_waitreq2", {31'b0, bus2.waitrequest}, 32'h0);

    for (int i = 0; i < 16; i++) begin ba[i] = AW'(i); bx[i] = 32'h0; end
    burst(16, "cleared");

    // byte-lane merge, read the cycle right after the write
    wr_word(5'd5, 4'hF, 32'hDEADBEEF);
    wr_word(5'd5, 4'h1, 32'h000000AA);
    ba[0] = 5'd5; bx[0] = 32'hDEADBEAA;
    burst(1, "be_merge");

    wr_word(5'd5, 4'h0, 32'hFFFFFFFF);
    wr_word(5'd0, 4'hF, 32'h01010101);
    wr_word(5'd1, 4'hF, 32'h02020202);
    wr_word(5'd2, 4'hF, 32'h03030303);
    wr_word(5'd3, 4'hF, 32'h04040404);
    ba[0] = 5'd0; bx[0] = 32'h01010101;
    ba[1] = 5'd1; bx[1] = 32'h02020202;
    ba[2] = 5'd2; bx[2] = 32'h03030303;
    ba[3] = 5'd3; bx[3] = 32'h04040404;
    ba[4] = 5'd5; bx[4] = 32'hDEADBEAA;
    burst(5, "pipe");

    // clken stall with a read in flight
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'h0, 32'h0);
      chk($sformatf("stall_waitreq_%0d", i), {31'b0, bus1.waitrequest}, 32'h1);
      chk($sformatf("stall_rdv1_%0d", i), {31'b0, bus1.readdatavalid}, 32'h0);
      chk($sformatf("stall_rdv2_%0d", i), {31'b0, bus2.readdatavalid}, 32'h0);
    end
    idle();
    chk("stall_rdv1_out", {31'b0, bus1.readdatavalid}, 32'h1);
    chk("stall_data1", bus1.readdata, 32'hDEADBEAA);
    chk("stall_rdv2_early", {31'b0, bus2.readdatavalid}, 32'h0);
    idle();
    chk("stall_rdv1_once", {31'b0, bus1.readdatavalid}, 32'h0);
    chk("stall_data1_hold", bus1.readdata, 32'hDEADBEAA);
    chk("stall_rdv2_out", {31'b0, bus2.readdatavalid}, 32'h1);
    chk("stall_data2", bus2.readdata, 32'hDEADBEAA);

    // reset_req blocks acceptance
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0);
    chk("rreq_waitreq", {31'b0, bus1.waitrequest}, 32'h1);
    idle();
    chk("rreq_rdv1", {31'b0, bus1.readdatavalid}, 32'h0);
    idle();
    chk("rreq_rdv2", {31'b0, bus2.readdatavalid}, 32'h0);

    // read and write together: write wins, no read response
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 4'hF, 32'h12345678);
    idle();
    chk("rw_rdv1", {31'b0, bus1.readdatavalid}, 32'h0);
    idle();
    chk("rw_rdv2", {31'b0, bus2.readdatavalid}, 32'h0);
    ba[0] = 5'd6; bx[0] = 32'h12345678;
    burst(1, "rw_data");
    chk("range_err_clean", {31'b0, range_err1}, 32'h0);

    // out-of-range read and write
    ba[0] = 5'd16; bx[0] = 32'h0;
    burst(1, "oor_read");
    chk("oor_range_err1", {31'b0, range_err1}, 32'h1);
    chk("oor_range_err2", {31'b0, range_err2}, 32'h1);
    wr_word(5'd16, 4'hF, 32'hFFFFFFFF);
    for (int i = 0; i < 16; i++) begin ba[i] = AW'(i); bx[i] = 32'h0; end
    bx[0] = 32'h01010101; bx[1] = 32'h02020202; bx[2] = 32'h03030303;
    bx[3] = 32'h04040404; bx[5] = 32'hDEADBEAA; bx[6] = 32'h12345678;
    burst(16, "after_oor");
    chk("oor_sticky", {31'b0, range_err1}, 32'h1);

    // reset with a read in flight
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0);
    @(negedge clk);
    bus1.chipselect = 1'b0; bus2.chipselect = 1'b0;
    reset = 1'b1; #1;
    chk("flush_rdv1", {31'b0, bus1.readdatavalid}, 32'h0);
    chk("flush_rdv2", {31'b0, bus2.readdatavalid}, 32'h0);
    chk("flush_range_err", {31'b0, range_err1}, 32'h0);
    chk("flush_readdata2", bus2.readdata, 32'h0);
    idle();
    chk("flush_rdv2_late", {31'b0, bus2.readdatavalid}, 32'h0);
    @(negedge clk); reset = 1'b0;
    n_all = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!bus1.waitrequest) break;
      n_all++;
      @(negedge clk);
    end
    chk("reclear_cycles", n_all, 16);
    ba[0] = 5'd5; bx[0] = 32'h0;
    burst(1, "reclear_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
